btb_predictor: RTL and testbench

Parametrised branch target buffer with per-entry saturating counters, serving the fetch stage of the MIPS pipeline. FETCH presents a PC and receives a registered target/taken prediction one cycle later. EXEC reports every resolved branch by PC, which trains the counter, refreshes the target, or allocates a new entry. Entries carry valid bits, cleared by reset and by a pipeline flush.

---
 rtl/btb_predictor.sv | 150 +++++++++++++++
 tb/tb_btb_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Branch target buffer for the fetch stage: fully associative lookup with a
// registered prediction, trained by resolved branches reported from EXEC.
module btb_predictor #(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 32,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid,
  output logic              f_hit,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target,
  input  logic              flush
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_d    [ENTRIES];
  logic [ADDR_W-1:0] tag_q    [ENTRIES];
  logic [ADDR_W-1:0] tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_d;

  logic [ADDR_W-1:0] f_predict_addr_q;
  logic [ADDR_W-1:0] f_predict_addr_d;
  logic              f_predict_valid_q;
  logic              f_predict_valid_d;
  logic              f_hit_q;
  logic              f_hit_d;

  logic              f_match;
  logic [IDX_W-1:0]  f_idx;
  logic              x_match;
  logic [IDX_W-1:0]  x_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim;

  // Tags are unique among valid entries, so the last match is the only match.
  always_comb begin
    f_match    = 1'b0;
    f_idx      = '0;
    x_match    = 1'b0;
    x_idx      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == f_pc)) begin
        f_match = 1'b1;
        f_idx   = IDX_W'(i);
      end
      if (valid_q[i] && (tag_q[i] == x_pc)) begin
        x_match = 1'b1;
        x_idx   = IDX_W'(i);
      end
    end
    // Scan downward so the lowest-index free entry wins.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    rr_ptr_d = rr_ptr_q;
    victim   = free_found ? free_idx : rr_ptr_q;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
      rr_ptr_d = '0;
    end else if (x_valid) begin
      if (x_match) begin
        if (x_taken) begin
          if (ctr_q[x_idx] != CTR_MAX) ctr_d[x_idx] = ctr_q[x_idx] + 1'b1;
          target_d[x_idx] = x_target;
        end else if (ctr_q[x_idx] != '0) begin
          ctr_d[x_idx] = ctr_q[x_idx] - 1'b1;
        end
      end else if (x_taken) begin
        valid_d[victim]  = 1'b1;
        tag_d[victim]    = x_pc;
        target_d[victim] = x_target;
        ctr_d[victim]    = CTR_INIT;
        if (!free_found) rr_ptr_d = rr_ptr_q + 1'b1;
      end
    end
  end

  // Prediction reflects pre-update state; address holds when no lookup is made.
  always_comb begin
    f_predict_addr_d  = f_predict_addr_q;
    f_hit_d           = 1'b0;
    f_predict_valid_d = 1'b0;
    if (f_valid) begin
      f_hit_d           = f_match;
      f_predict_valid_d = f_match && ctr_q[f_idx][CTR_W-1];
      f_predict_addr_d  = f_match ? target_q[f_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      rr_ptr_q          <= '0;
      f_predict_addr_q  <= '0;
      f_predict_valid_q <= 1'b0;
      f_hit_q           <= 1'b0;
    end else begin
      valid_q           <= valid_d;
      ctr_q             <= ctr_d;
      rr_ptr_q          <= rr_ptr_d;
      f_predict_addr_q  <= f_predict_addr_d;
      f_predict_valid_q <= f_predict_valid_d;
      f_hit_q           <= f_hit_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign f_predict_addr  = f_predict_addr_q;
  assign f_predict_valid = f_predict_valid_q;
  assign f_hit           = f_hit_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: one table row per clock cycle with the
// expected registered prediction, plus an asynchronous reset sequence.
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_predict_addr;
  logic        f_predict_valid;
  logic        f_hit;
  logic        x_valid;
  logic [31:0] x_pc;
  logic        x_taken;
  logic [31:0] x_target;
  logic        flush;

  int checks;
  int errors;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        xv;
    logic [31:0] xpc;
    logic        xt;
    logic [31:0] xtgt;
    logic        fl;
    logic        eh;
    logic        epv;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  btb_predictor #(.ENTRIES(4), .ADDR_W(32), .CTR_W(2), .INIT_CTR(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .f_valid         (f_valid),
    .f_pc            (f_pc),
    .f_predict_addr  (f_predict_addr),
    .f_predict_valid (f_predict_valid),
    .f_hit           (f_hit),
    .x_valid         (x_valid),
    .x_pc            (x_pc),
    .x_taken         (x_taken),
    .x_target        (x_target),
    .flush           (flush)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic eh, input logic epv, input logic [31:0] ea);
    check({tag, " f_hit"}, {31'd0, f_hit}, {31'd0, eh});
    check({tag, " f_predict_valid"}, {31'd0, f_predict_valid}, {31'd0, epv});
    check({tag, " f_predict_addr"}, f_predict_addr, ea);
  endtask

  task automatic add_vec(input logic fv, input logic [31:0] fpc, input logic xv,
                         input logic [31:0] xpc, input logic xt, input logic [31:0] xtgt,
                         input logic fl, input logic eh, input logic epv, input logic [31:0] ea);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.xv = xv; v.xpc = xpc; v.xt = xt; v.xtgt = xtgt;
    v.fl = fl; v.eh = eh; v.epv = epv; v.ea = ea;
    vecs.push_back(v);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 after rising edge.
  task automatic drive(input logic fv, input logic [31:0] fpc, input logic xv,
                       input logic [31:0] xpc, input logic xt, input logic [31:0] xtgt,
                       input logic fl);
    @(negedge clk);
    f_valid = fv; f_pc = fpc; x_valid = xv; x_pc = xpc;
    x_taken = xt; x_target = xtgt; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    f_valid = 1'b0; f_pc = '0; x_valid = 1'b0; x_pc = '0;
    x_taken = 1'b0; x_target = '0; flush = 1'b0;

    //       fv  fpc         xv  xpc         xt  xtgt        fl  eh  epv ea
    add_vec(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);    // empty miss
    add_vec(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 0, 32'h0);    // same-cycle alloc
    add_vec(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h200);  // ctr 2
    add_vec(1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 32'h200);  // ->1
    add_vec(1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h200);  // ->0
    add_vec(1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h200);  // stays 0
    add_vec(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h200);
    add_vec(0, 32'h0,   1, 32'h100, 1, 32'h204, 0, 0, 0, 32'h200);  // ->1, addr holds
    add_vec(1, 32'h100, 1, 32'h100, 1, 32'h208, 0, 1, 0, 32'h204);  // ->2
    add_vec(1, 32'h100, 1, 32'h100, 1, 32'h20c, 0, 1, 1, 32'h208);  // ->3
    add_vec(1, 32'h100, 1, 32'h100, 1, 32'h210, 0, 1, 1, 32'h20c);  // stays 3
    add_vec(1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 32'h210);  // ->2
    add_vec(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h210);
    add_vec(1, 32'h500, 1, 32'h500, 0, 32'h0,   0, 0, 0, 32'h0);    // NT miss: no alloc
    add_vec(1, 32'h500, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    add_vec(1, 32'h100, 1, 32'h300, 1, 32'h310, 1, 1, 1, 32'h210);  // flush wins
    add_vec(1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    add_vec(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    add_vec(0, 32'h0,   1, 32'h10,  1, 32'h1010, 0, 0, 0, 32'h0);   // entry 0
    add_vec(0, 32'h0,   1, 32'h20,  1, 32'h1020, 0, 0, 0, 32'h0);   // entry 1
    add_vec(0, 32'h0,   1, 32'h30,  1, 32'h1030, 0, 0, 0, 32'h0);   // entry 2
    add_vec(0, 32'h0,   1, 32'h40,  1, 32'h1040, 0, 0, 0, 32'h0);   // entry 3
    add_vec(1, 32'h10,  1, 32'h50,  1, 32'h1050, 0, 1, 1, 32'h1010); // 0x50 over 0x10
    add_vec(1, 32'h10,  1, 32'h60,  1, 32'h1060, 0, 0, 0, 32'h0);   // 0x60 over 0x20
    add_vec(1, 32'h20,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    add_vec(1, 32'h30,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h1030);
    add_vec(1, 32'h50,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h1050);
    add_vec(1, 32'h60,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h1060);
    add_vec(1, 32'h40,  1, 32'h40,  0, 32'h0,   0, 1, 1, 32'h1040); // ctr 2->1
    add_vec(1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h1040);
    add_vec(0, 32'h0,   1, 32'h70,  1, 32'h1070, 0, 0, 0, 32'h1040); // over 0x30
    add_vec(0, 32'h0,   1, 32'h80,  1, 32'h1080, 0, 0, 0, 32'h1040); // over 0x40, rr wraps
    add_vec(0, 32'h0,   1, 32'h90,  1, 32'h1090, 0, 0, 0, 32'h1040); // over 0x50
    add_vec(1, 32'h50,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    add_vec(1, 32'h60,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h1060);
    add_vec(1, 32'h90,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h1090);
    add_vec(1, 32'h80,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h1080);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outs("reset", 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].xv, vecs[i].xpc,
            vecs[i].xt, vecs[i].xtgt, vecs[i].fl);
      check_outs($sformatf("v%0d", i), vecs[i].eh, vecs[i].epv, vecs[i].ea);
    end

    // Asynchronous reset between edges while a prediction is being shown.
    drive(1, 32'h60, 0, 32'h0, 0, 32'h0, 0);
    check_outs("pre_async_rst", 1'b1, 1'b1, 32'h1060);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h60, 0, 32'h0, 0, 32'h0, 0);
    check_outs("post_rst_lookup", 1'b0, 1'b0, 32'h0);
    drive(1, 32'h60, 1, 32'h60, 1, 32'h2060, 0);
    check_outs("post_rst_same_cycle", 1'b0, 1'b0, 32'h0);
    drive(1, 32'h60, 0, 32'h0, 0, 32'h0, 0);
    check_outs("post_rst_realloc", 1'b1, 1'b1, 32'h2060);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
